// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared ASCII constants and stream state type for the counter streamer
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_CR,
    ST_LF
  } stream_state_e;

endpackage

// File: rtl/ascii_digit_sync.sv
// rtl/ascii_digit_sync.sv - one clocked ASCII decimal digit with combinational carry out
module ascii_digit_sync
  import ascii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= ASCII_ZERO;
    end else if (clear) begin
      value <= ASCII_ZERO;
    end else if (inc) begin
      value <= (value == ASCII_NINE) ? ASCII_ZERO : value + 8'd1;
    end
  end

  assign carry = inc & (value == ASCII_NINE);

endmodule

// File: rtl/ascii_count_streamer.sv
// rtl/ascii_count_streamer.sv - ASCII decimal counter that streams each new value as bytes
// Optional CR/LF frame trailer enabled by defining ASCII_STREAM_CRLF_EN.
module ascii_count_streamer
  import ascii_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc_req,
  input  logic                    clear,
  output logic                    inc_ack,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    overflow,
  output logic                    missed,
  output logic [8*NUM_DIGITS-1:0] digits
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NUM_DIGITS - 1);

  stream_state_e       state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pending_q;
  logic                xfer;
  logic                frame_end;
  logic                restart;
  logic                accept;
  logic [NUM_DIGITS:0] inc_chain;

  assign xfer = (state_q != ST_IDLE) & tx_ready;
`ifdef ASCII_STREAM_CRLF_EN
  assign frame_end = xfer & (state_q == ST_LF);
`else
  assign frame_end = xfer & (state_q == ST_SEND) & (idx_q == '0);
`endif
  assign restart   = pending_q | inc_req;
  assign accept    = !clear & (((state_q == ST_IDLE) & inc_req) | (frame_end & restart));
  assign inc_chain[0] = accept;

  // Carry ripples combinationally so the whole counter advances on the accepting edge.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    ascii_digit_sync u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .inc   (inc_chain[g]),
      .value (digits[8*g +: 8]),
      .carry (inc_chain[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = ST_IDLE;
      idx_d   = TOP_IDX;
    end else if (accept) begin
      state_d = ST_SEND;
      idx_d   = TOP_IDX;
    end else if (frame_end) begin
      state_d = ST_IDLE;
      idx_d   = TOP_IDX;
    end else if (xfer) begin
      case (state_q)
        ST_SEND: begin
          if (idx_q != '0) idx_d = idx_q - IW'(1);
`ifdef ASCII_STREAM_CRLF_EN
          else state_d = ST_CR;
`endif
        end
`ifdef ASCII_STREAM_CRLF_EN
        ST_CR:   state_d = ST_LF;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_data = digits[{idx_q, 3'b000} +: 8];
`ifdef ASCII_STREAM_CRLF_EN
    if (state_q == ST_CR) tx_data = ASCII_CR;
    if (state_q == ST_LF) tx_data = ASCII_LF;
`endif
  end

  assign tx_valid = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= TOP_IDX;
      inc_ack   <= 1'b0;
      pending_q <= 1'b0;
      missed    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      inc_ack <= accept;
      if (clear) begin
        pending_q <= 1'b0;
        missed    <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (inc_chain[NUM_DIGITS]) overflow <= 1'b1;
        // At frame end a held pending is consumed and a coincident request takes its place.
        if (frame_end) begin
          pending_q <= pending_q & inc_req;
        end else if ((state_q != ST_IDLE) && inc_req) begin
          if (pending_q) missed <= 1'b1;
          else pending_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ascii_count_streamer.sv
// tb/tb_ascii_count_streamer.sv - randomized and directed bench with a queue-based frame model
module tb_ascii_count_streamer;

  localparam int N    = 4;
  localparam int MODV = 10000;
`ifdef ASCII_STREAM_CRLF_EN
  localparam int NB = N + 2;
`else
  localparam int NB = N;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           inc_req;
  logic           clear;
  logic           inc_ack;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic           overflow;
  logic           missed;
  logic [8*N-1:0] digits;

  always #5 clk = ~clk;

  ascii_count_streamer #(.NUM_DIGITS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_req  (inc_req),
    .clear    (clear),
    .inc_ack  (inc_ack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overflow (overflow),
    .missed   (missed),
    .digits   (digits)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: integer counter plus the queue of bytes still owed in the current frame.
  int         m_count;
  bit         m_ovf, m_missed, m_pend, m_ack;
  logic [7:0] m_q[$];

  function automatic logic [8*N-1:0] ascii_of(input int v);
    logic [8*N-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[8*i +: 8] = 8'h30 + 8'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_ovf = 0; m_missed = 0; m_pend = 0; m_ack = 0;
    m_q.delete();
  endtask

  task automatic model_bump();
    logic [8*N-1:0] d;
    m_count++;
    if (m_count == MODV) begin
      m_count = 0;
      m_ovf = 1;
    end
    d = ascii_of(m_count);
    m_q.delete();
    for (int i = N - 1; i >= 0; i--) m_q.push_back(d[8*i +: 8]);
`ifdef ASCII_STREAM_CRLF_EN
    m_q.push_back(8'h0D);
    m_q.push_back(8'h0A);
`endif
    m_ack = 1;
  endtask

  task automatic model_edge(input bit r, input bit c, input bit rd);
    m_ack = 0;
    if (c) begin
      m_count = 0; m_ovf = 0; m_missed = 0; m_pend = 0;
      m_q.delete();
    end else if (m_q.size() == 0) begin
      if (r) model_bump();
    end else if (rd && m_q.size() == 1) begin
      void'(m_q.pop_front());
      if (m_pend || r) begin
        model_bump();
        m_pend = m_pend & r;
      end
    end else begin
      if (rd) void'(m_q.pop_front());
      if (r) begin
        if (m_pend) m_missed = 1;
        else m_pend = 1;
      end
    end
  endtask

  task automatic check_all();
    check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    check("busy", 32'(busy), 32'(m_q.size() != 0));
    check("inc_ack", 32'(inc_ack), 32'(m_ack));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("missed", 32'(missed), 32'(m_missed));
    check("digits", digits, ascii_of(m_count));
    if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
  endtask

  task automatic step();
    bit r, c, rd;
    r = inc_req; c = clear; rd = tx_ready;
    @(posedge clk);
    model_edge(r, c, rd);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) step();
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  logic [7:0] got_q[$];
  logic [7:0] exp1[6] = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};

  initial begin
    rst_n = 1'b0; inc_req = 1'b0; clear = 1'b0; tx_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h30);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_digits", digits, 32'h30303030);
    check("rst_flags", {28'd0, inc_ack, busy, overflow, missed}, 32'd0);
    rst_n = 1'b1;
    step();

    // First frame after reset
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    check("t1_ack", 32'(inc_ack), 32'd1);
    for (int k = 0; k < 20 && tx_valid; k++) begin
      got_q.push_back(tx_data);
      step();
    end
    check("t1_len", got_q.size(), NB);
    for (int i = 0; i < NB && i < got_q.size(); i++) check("t1_byte", 32'(got_q[i]), 32'(exp1[i]));
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_digits", digits, 32'h30303031);

    // Stall mid-frame
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    step();
    tx_ready = 1'b0;
    repeat (5) begin
      step();
      check("stall_data", 32'(tx_data), 32'h30);
      check("stall_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    wait_idle();
    check("stall_digits", digits, 32'h30303032);

    // Three requests during one stalled frame
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    tx_ready = 1'b0;
    repeat (3) begin
      inc_req = 1'b1; step();
      inc_req = 1'b0; step();
    end
    check("multi_missed", 32'(missed), 32'd1);
    tx_ready = 1'b1;
    wait_idle();
    check("multi_digits", digits, 32'h30303034);

    // Clear during the second digit with a coincident request
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    step();
    clear = 1'b1; inc_req = 1'b1;
    step();
    clear = 1'b0; inc_req = 1'b0;
    check("clr_valid", 32'(tx_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_digits", digits, 32'h30303030);
    check("clr_ack", 32'(inc_ack), 32'd0);
    step();
    check("clr_no_pend", 32'(busy), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      inc_req  = ($urandom_range(0, 9) == 0);
      tx_ready = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 199) == 0);
      step();
    end
    inc_req = 1'b0; clear = 1'b0; tx_ready = 1'b1;
    wait_idle();

    // Preload 9999, then wrap
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 9999 * NB + 50 && m_count != 9999; k++) begin
      inc_req = (m_q.size() <= 1);
      step();
    end
    inc_req = 1'b0;
    wait_idle();
    check("preload_digits", digits, 32'h39393939);
    check("preload_ovf", 32'(overflow), 32'd0);
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    check("wrap_ovf", 32'(overflow), 32'd1);
    check("wrap_data", 32'(tx_data), 32'h30);
    wait_idle();
    check("wrap_digits", digits, 32'h30303030);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("wrap_clr_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset mid-frame
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    step();
    @(posedge clk);
    model_edge(1'b0, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", 32'(tx_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_data", 32'(tx_data), 32'h30);
    check("arst_digits", digits, 32'h30303030);
    check("arst_flags", {29'd0, inc_ack, overflow, missed}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    inc_req = 1'b1;
    step();
    inc_req = 1'b0;
    wait_idle();
    check("arst_after", digits, 32'h30303031);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
